// File: rtl/decode_cycle_pkg.sv
// rtl/decode_cycle_pkg.sv - RV32I decode-stage constants, control encodings and immediate extension
package decode_cycle_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int REGW  = 5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctl_e;

    typedef struct packed {
        logic        reg_write;
        imm_src_e    imm_src;
        logic        alu_src;
        logic        mem_write;
        result_src_e result_src;
        logic        branch;
        alu_op_e     alu_op;
        logic        jump;
    } ctrl_t;

    typedef struct packed {
        logic             reg_write;
        logic             mem_write;
        logic             jump;
        logic             branch;
        logic             alu_src;
        logic [1:0]       result_src;
        logic [2:0]       alu_ctl;
        logic [XLEN-1:0]  rd1;
        logic [XLEN-1:0]  rd2;
        logic [XLEN-1:0]  imm;
        logic [REGW-1:0]  rd;
        logic [REGW-1:0]  rs1;
        logic [REGW-1:0]  rs2;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  pc_plus4;
    } de_t;

    function automatic logic [XLEN-1:0] imm_extend(input logic [XLEN-1:0] instr,
                                                   input imm_src_e        src);
        logic [XLEN-1:0] imm;
        case (src)
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = {{20{instr[31]}}, instr[31:20]};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_cycle_register_file.sv
// rtl/decode_cycle_register_file.sv - 32x32 register file, two bypassed read ports, one write port
module register_file
    import decode_cycle_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_we,
    input  logic [REGW-1:0] i_wa,
    input  logic [XLEN-1:0] i_wd,
    input  logic [REGW-1:0] i_ra1,
    input  logic [REGW-1:0] i_ra2,
    output logic [XLEN-1:0] o_rd1,
    output logic [XLEN-1:0] o_rd2
);

    logic [XLEN-1:0] r_regs [NREGS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_wa != '0)) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    // x0 is hardwired; a same-cycle writeback to the read index is forwarded
    assign o_rd1 = (i_ra1 == '0)              ? '0   :
                   (i_we && (i_wa == i_ra1))  ? i_wd : r_regs[i_ra1];
    assign o_rd2 = (i_ra2 == '0)              ? '0   :
                   (i_we && (i_wa == i_ra2))  ? i_wd : r_regs[i_ra2];

endmodule

// File: rtl/decode_cycle.sv
// rtl/decode_cycle.sv - RV32I decode stage: control decode, register read, immediate extend, D/E register
module decode_cycle
    import decode_cycle_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            RegWriteW,
    input  logic [REGW-1:0] RDW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            FlushE,
    output logic [REGW-1:0] Rs1D,
    output logic [REGW-1:0] Rs2D,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic            ALUSrcE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [REGW-1:0] RdE,
    output logic [REGW-1:0] Rs1E,
    output logic [REGW-1:0] Rs2E,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E
);

    ctrl_t           w_ctrl;
    alu_ctl_e        w_alu_ctl;
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;
    de_t             w_de_next;
    de_t             r_de;

    assign Rs1D = InstrD[19:15];
    assign Rs2D = InstrD[24:20];

    register_file u_register_file (
        .clk   (clk),
        .rst   (rst),
        .i_we  (RegWriteW),
        .i_wa  (RDW),
        .i_wd  (ResultW),
        .i_ra1 (Rs1D),
        .i_ra2 (Rs2D),
        .o_rd1 (w_rd1),
        .o_rd2 (w_rd2)
    );

    // Unknown opcodes leave every control at 0 so they flow down as bubbles
    always_comb begin
        w_ctrl = '0;
        case (InstrD[6:0])
            OP_LOAD: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.result_src = RES_MEM;
            end
            OP_STORE: begin
                w_ctrl.imm_src    = IMM_S;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.mem_write  = 1'b1;
            end
            OP_RTYPE: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.alu_op     = ALUOP_FUNCT;
            end
            OP_BRANCH: begin
                w_ctrl.imm_src    = IMM_B;
                w_ctrl.branch     = 1'b1;
                w_ctrl.alu_op     = ALUOP_SUB;
            end
            OP_ITYPE: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.alu_op     = ALUOP_FUNCT;
            end
            OP_JAL: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.imm_src    = IMM_J;
                w_ctrl.result_src = RES_PC4;
                w_ctrl.jump       = 1'b1;
            end
            default: w_ctrl = '0;
        endcase
    end

    // funct7[5] selects sub only for register-register ops (op[5]=1); addi keeps add
    always_comb begin
        w_alu_ctl = ALU_ADD;
        case (w_ctrl.alu_op)
            ALUOP_SUB: w_alu_ctl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (InstrD[14:12])
                    3'b000:  w_alu_ctl = ({InstrD[5], InstrD[30]} == 2'b11) ? ALU_SUB : ALU_ADD;
                    3'b010:  w_alu_ctl = ALU_SLT;
                    3'b110:  w_alu_ctl = ALU_OR;
                    3'b111:  w_alu_ctl = ALU_AND;
                    default: w_alu_ctl = ALU_ADD;
                endcase
            end
            default: w_alu_ctl = ALU_ADD;
        endcase
    end

    always_comb begin
        w_de_next            = '0;
        w_de_next.reg_write  = w_ctrl.reg_write;
        w_de_next.mem_write  = w_ctrl.mem_write;
        w_de_next.jump       = w_ctrl.jump;
        w_de_next.branch     = w_ctrl.branch;
        w_de_next.alu_src    = w_ctrl.alu_src;
        w_de_next.result_src = w_ctrl.result_src;
        w_de_next.alu_ctl    = w_alu_ctl;
        w_de_next.rd1        = w_rd1;
        w_de_next.rd2        = w_rd2;
        w_de_next.imm        = imm_extend(InstrD, w_ctrl.imm_src);
        w_de_next.rd         = InstrD[11:7];
        w_de_next.rs1        = Rs1D;
        w_de_next.rs2        = Rs2D;
        w_de_next.pc         = PCD;
        w_de_next.pc_plus4   = PCPlus4D;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_de <= '0;
        end else if (FlushE) begin
            r_de <= '0;
        end else begin
            r_de <= w_de_next;
        end
    end

    assign RegWriteE   = r_de.reg_write;
    assign MemWriteE   = r_de.mem_write;
    assign JumpE       = r_de.jump;
    assign BranchE     = r_de.branch;
    assign ALUSrcE     = r_de.alu_src;
    assign ResultSrcE  = r_de.result_src;
    assign ALUControlE = r_de.alu_ctl;
    assign RD1E        = r_de.rd1;
    assign RD2E        = r_de.rd2;
    assign ImmExtE     = r_de.imm;
    assign RdE         = r_de.rd;
    assign Rs1E        = r_de.rs1;
    assign Rs2E        = r_de.rs2;
    assign PCE         = r_de.pc;
    assign PCPlus4E    = r_de.pc_plus4;

endmodule

// File: tb/tb_decode_cycle.sv
// tb/tb_decode_cycle.sv - scoreboard bench for decode_cycle with hand-computed directed vectors
module tb_decode_cycle;

    typedef struct {
        logic        rw;
        logic        mw;
        logic        j;
        logic        b;
        logic        as;
        logic [1:0]  rs;
        logic [2:0]  alu;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic        imm_care;
        logic [4:0]  rd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] InstrD = '0;
    logic [31:0] PCD = '0;
    logic [31:0] PCPlus4D = '0;
    logic        RegWriteW = 1'b0;
    logic [4:0]  RDW = '0;
    logic [31:0] ResultW = '0;
    logic        FlushE = 1'b0;
    logic [4:0]  Rs1D, Rs2D;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE;
    logic [4:0]  RdE, Rs1E, Rs2E;
    logic [31:0] PCE, PCPlus4E;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    decode_cycle dut (
        .clk         (clk),
        .rst         (rst),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .RegWriteW   (RegWriteW),
        .RDW         (RDW),
        .ResultW     (ResultW),
        .FlushE      (FlushE),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .RegWriteE   (RegWriteE),
        .MemWriteE   (MemWriteE),
        .JumpE       (JumpE),
        .BranchE     (BranchE),
        .ALUSrcE     (ALUSrcE),
        .ResultSrcE  (ResultSrcE),
        .ALUControlE (ALUControlE),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .ImmExtE     (ImmExtE),
        .RdE         (RdE),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .PCE         (PCE),
        .PCPlus4E    (PCPlus4E)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic rw, input logic mw, input logic j, input logic b,
                                input logic as, input logic [1:0] rs, input logic [2:0] alu,
                                input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [31:0] imm, input logic ic,
                                input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                                input logic [31:0] pc);
        exp_t e;
        e.rw = rw; e.mw = mw; e.j = j; e.b = b; e.as = as; e.rs = rs; e.alu = alu;
        e.rd1 = rd1; e.rd2 = rd2; e.imm = imm; e.imm_care = ic;
        e.rd = rd; e.r1 = r1; e.r2 = r2; e.pc = pc; e.pc4 = pc + 32'd4;
        return e;
    endfunction

    function automatic exp_t zero_e();
        exp_t e;
        e = mk(0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 1'b1, 0, 0, 0, 0);
        e.pc4 = '0;
        return e;
    endfunction

    task automatic step(input logic r, input logic [31:0] instr, input logic [31:0] pc,
                        input logic we, input logic [4:0] rdw, input logic [31:0] res,
                        input logic fl, input exp_t e);
        @(negedge clk);
        rst       = r;
        InstrD    = instr;
        PCD       = pc;
        PCPlus4D  = pc + 32'd4;
        RegWriteW = we;
        RDW       = rdw;
        ResultW   = res;
        FlushE    = fl;
        sb.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("RegWriteE",   {31'd0, RegWriteE}, {31'd0, mon_e.rw});
                chk("MemWriteE",   {31'd0, MemWriteE}, {31'd0, mon_e.mw});
                chk("JumpE",       {31'd0, JumpE},     {31'd0, mon_e.j});
                chk("BranchE",     {31'd0, BranchE},   {31'd0, mon_e.b});
                chk("ALUSrcE",     {31'd0, ALUSrcE},   {31'd0, mon_e.as});
                chk("ResultSrcE",  {30'd0, ResultSrcE},  {30'd0, mon_e.rs});
                chk("ALUControlE", {29'd0, ALUControlE}, {29'd0, mon_e.alu});
                chk("RD1E", RD1E, mon_e.rd1);
                chk("RD2E", RD2E, mon_e.rd2);
                if (mon_e.imm_care) chk("ImmExtE", ImmExtE, mon_e.imm);
                chk("RdE",  {27'd0, RdE},  {27'd0, mon_e.rd});
                chk("Rs1E", {27'd0, Rs1E}, {27'd0, mon_e.r1});
                chk("Rs2E", {27'd0, Rs2E}, {27'd0, mon_e.r2});
                chk("PCE", PCE, mon_e.pc);
                chk("PCPlus4E", PCPlus4E, mon_e.pc4);
            end
        end
    end

    initial begin
        // reset held: outputs stay zero
        step(0, 32'h00500293, 32'h100, 0, 0, 0, 0, zero_e());
        // addi x5,x0,5
        step(1, 32'h00500293, 32'h100, 0, 0, 0, 0,
             mk(1, 0, 0, 0, 1, 2'b00, 3'b000, 0, 0, 32'd5, 1, 5, 0, 5, 32'h100));
        // preload x5=9, x6=4 through writeback while decoding bubbles
        step(1, 32'h0, 32'h104, 1, 5, 32'd9, 0,
             mk(0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 1, 0, 0, 0, 32'h104));
        step(1, 32'h0, 32'h108, 1, 6, 32'd4, 0,
             mk(0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 1, 0, 0, 0, 32'h108));
        // sub x6,x5,x6
        step(1, 32'h40628333, 32'h10C, 0, 0, 0, 0,
             mk(1, 0, 0, 0, 0, 2'b00, 3'b001, 32'd9, 32'd4, 0, 0, 6, 5, 6, 32'h10C));
        #1;
        chk("Rs1D", {27'd0, Rs1D}, 32'd5);
        chk("Rs2D", {27'd0, Rs2D}, 32'd6);
        // bypass: add x8,x7,x0 while x7 is being written
        step(1, 32'h00038433, 32'h110, 1, 7, 32'hDEADBEEF, 0,
             mk(1, 0, 0, 0, 0, 2'b00, 3'b000, 32'hDEADBEEF, 0, 0, 0, 8, 7, 0, 32'h110));
        // write to x0 is not forwarded: add x8,x0,x0
        step(1, 32'h00000433, 32'h114, 1, 0, 32'h12345678, 0,
             mk(1, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 8, 0, 0, 32'h114));
        // x7 kept the bypassed write
        step(1, 32'h00038433, 32'h118, 0, 0, 0, 0,
             mk(1, 0, 0, 0, 0, 2'b00, 3'b000, 32'hDEADBEEF, 0, 0, 0, 8, 7, 0, 32'h118));
        // beq x0,x0,-4
        step(1, 32'hFE000EE3, 32'h120, 0, 0, 0, 0,
             mk(0, 0, 0, 1, 0, 2'b00, 3'b001, 0, 0, 32'hFFFFFFFC, 1, 29, 0, 0, 32'h120));
        // jal x1,8
        step(1, 32'h008000EF, 32'h124, 0, 0, 0, 0,
             mk(1, 0, 1, 0, 0, 2'b10, 3'b000, 0, 0, 32'd8, 1, 1, 0, 8, 32'h124));
        // sw x6,4(x5) flushed
        step(1, 32'h0062A223, 32'h128, 0, 0, 0, 1, zero_e());
        // sw x6,4(x5)
        step(1, 32'h0062A223, 32'h12C, 0, 0, 0, 0,
             mk(0, 1, 0, 0, 1, 2'b00, 3'b000, 32'd9, 32'd4, 32'd4, 1, 4, 5, 6, 32'h12C));
        // lw x9,8(x6)
        step(1, 32'h00832483, 32'h130, 0, 0, 0, 0,
             mk(1, 0, 0, 0, 1, 2'b01, 3'b000, 32'd4, 0, 32'd8, 1, 9, 6, 8, 32'h130));
        // ori x10,x5,-1
        step(1, 32'hFFF2E513, 32'h134, 0, 0, 0, 0,
             mk(1, 0, 0, 0, 1, 2'b00, 3'b011, 32'd9, 0, 32'hFFFFFFFF, 1, 10, 5, 31, 32'h134));
        // and x11,x5,x6
        step(1, 32'h0062F5B3, 32'h138, 0, 0, 0, 0,
             mk(1, 0, 0, 0, 0, 2'b00, 3'b010, 32'd9, 32'd4, 0, 0, 11, 5, 6, 32'h138));
        // slt x12,x6,x5
        step(1, 32'h00532633, 32'h13C, 0, 0, 0, 0,
             mk(1, 0, 0, 0, 0, 2'b00, 3'b101, 32'd4, 32'd9, 0, 0, 12, 6, 5, 32'h13C));
        // addi x13,x5,0x400: imm bit 30 set must not turn into sub
        step(1, 32'h40028693, 32'h140, 0, 0, 0, 0,
             mk(1, 0, 0, 0, 1, 2'b00, 3'b000, 32'd9, 0, 32'h400, 1, 13, 5, 0, 32'h140));
        // mid-run asynchronous reset
        step(0, 32'h00028433, 32'h144, 0, 0, 0, 0, zero_e());
        #1;
        chk("async_RegWriteE", {31'd0, RegWriteE}, 32'd0);
        chk("async_RD1E", RD1E, 32'd0);
        // x5 cleared by reset: add x8,x5,x0
        step(1, 32'h00028433, 32'h148, 0, 0, 0, 0,
             mk(1, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 8, 5, 0, 32'h148));

        for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
        #3;
        if (sb.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
